// File: rtl/rr_lock_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Brief    : Shared types, default constants and helpers for rr_lock_arbiter.
// Revision : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

  // Arbiter control states: IDLE arbitrates, BUSY holds the current owner.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Largest supported requester count and the matching index width.
  localparam int MAX_N   = 16;
  localparam int MAX_IDW = 4;

  // One-hot to binary index; an all-zero input yields 0.
  function automatic logic [MAX_IDW-1:0] onehot2bin(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) begin
        bin = bin | MAX_IDW'(i);
      end
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_lock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter_if
// Brief    : Request/grant bundle between requesters (master) and the
//            arbiter (slave).
// Revision : 1.0  initial release
// ============================================================================
interface rr_lock_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_lock_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating-priority picker. Searches req starting at
//            ptr, wrapping to bit 0, and returns a one-hot winner.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   winner,
  output logic           any_valid
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_src;

  // Mask keeps bits at or above ptr; if none of those request, fall back to
  // the unmasked vector, which is exactly the wrap-around part of the search.
  // The lowest set bit of the chosen vector is the winner.
  always_comb begin
    w_mask    = ~((N'(1) << ptr) - N'(1));
    w_masked  = req & w_mask;
    w_src     = (|w_masked) ? w_masked : req;
    winner    = w_src & (~w_src + N'(1));
    any_valid = |req;
  end

endmodule
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter
// Brief    : Round-robin arbiter with grant locking. One registered one-hot
//            grant, held until the owner pulses done or drops req; every
//            grant is followed by at least one idle cycle.
//            Optional macro RR_LOCK_ARBITER_TIMEOUT_EN adds a hold limit of
//            MAX_HOLD cycles after which the grant is revoked and timeout
//            pulses for one cycle.
// Revision : 1.0  initial release
// ============================================================================
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IDW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_lock_arbiter_if.slave  bus
);

  if (N < 2 || N > MAX_N || MAX_HOLD < 2) begin : g_param_check
    $error("rr_lock_arbiter: unsupported parameter set");
  end

  state_e         r_state;
  state_e         w_state_nxt;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   w_grant_nxt;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_id_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic           r_timeout;
  logic           w_timeout_nxt;

  logic [N-1:0]   w_win;
  logic           w_any;
  logic [IDW-1:0] w_win_id;
  logic [IDW-1:0] w_ptr_adv;
  logic           w_release;
  logic           w_hold_expire;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req       (bus.req),
    .ptr       (r_ptr),
    .winner    (w_win),
    .any_valid (w_any)
  );

  assign w_win_id  = IDW'(onehot2bin(MAX_N'(w_win)));
  // Priority moves to the requester just after the current owner.
  assign w_ptr_adv = (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
  // Only the owner's done/req bits matter while BUSY.
  assign w_release = bus.done[r_id] | ~bus.req[r_id];

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HCW-1:0] r_hold_cnt;

  // Hold counter: zero while idle (so zero on the first granted cycle),
  // counts BUSY cycles and saturates at MAX_HOLD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HCW'(MAX_HOLD - 1)) begin
      r_hold_cnt <= r_hold_cnt + HCW'(1);
    end
  end

  assign w_hold_expire = (r_state == BUSY) && (r_hold_cnt == HCW'(MAX_HOLD - 1));
`else
  assign w_hold_expire = 1'b0;
`endif

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_id      <= w_id_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold/release in BUSY. A voluntary
  // release wins over a coincident hold-limit expiry, so timeout only flags
  // genuine revocations.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_id;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_win;
          w_id_nxt    = w_win_id;
          w_state_nxt = BUSY;
        end else begin
          w_grant_nxt = '0;
          w_id_nxt    = '0;
        end
      end
      BUSY: begin
        if (w_release || w_hold_expire) begin
          w_grant_nxt   = '0;
          w_id_nxt      = '0;
          w_ptr_nxt     = w_ptr_adv;
          w_state_nxt   = IDLE;
          w_timeout_nxt = ~w_release;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_id_nxt    = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = |r_grant;
  assign bus.grant_id    = r_id;
  assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_lock_arbiter
// Brief    : Self-checking bench for rr_lock_arbiter: cycle-level reference
//            model plus directed scenarios with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_lock_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  rr_lock_arbiter_if #(.N(N)) bus ();

  rr_lock_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Owner index (-1 when nobody holds the resource), priority start point,
  // number of cycles the current owner has held the grant, timeout flag.
  int m_owner   = -1;
  int m_ptr     = 0;
  int m_held    = 0;
  bit m_timeout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner   = -1;
      m_ptr     = 0;
      m_held    = 0;
      m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_owner < 0) begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (!found && bus.req[j]) begin
            found   = 1'b1;
            m_owner = j;
            m_held  = 1;
          end
        end
      end else if (!bus.req[m_owner] || bus.done[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (TO_EN && m_held == MAX_HOLD) begin
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
        m_timeout = 1'b1;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? N'(1) << m_owner : '0;
  endfunction

  function automatic int exp_id();
    return (m_owner >= 0) ? m_owner : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_grant",   32'(bus.grant),       32'(exp_grant()));
      check("cyc_valid",   32'(bus.grant_valid), 32'(m_owner >= 0));
      check("cyc_id",      32'(bus.grant_id),    32'(exp_id()));
      check("cyc_timeout", 32'(bus.timeout),     32'(m_timeout));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g, input int id);
    check({name, "_grant"}, 32'(bus.grant),       32'(g));
    check({name, "_valid"}, 32'(bus.grant_valid), 32'(g != '0));
    check({name, "_id"},    32'(bus.grant_id),    32'(id));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    repeat (2) tick();
    expect_out("rst", 4'b0000, 0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [N-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    bus.req  = '0;
    bus.done = '0;
    do_reset();

    // Single requester, done release, pointer moves to 2.
    bus.req = 4'b0010;
    tick();
    expect_out("s1_grant1", 4'b0010, 1);
    bus.done = 4'b0010;
    tick();
    bus.done = '0;
    expect_out("s1_release", 4'b0000, 0);
    check("s1_model_ptr", 32'(m_ptr), 32'd2);
    bus.req = 4'b0101;
    tick();
    expect_out("s1_ptr2", 4'b0100, 2);
    bus.req = '0;
    repeat (2) tick();

    // All requesting: strict rotation with an idle cycle between grants.
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out($sformatf("s2_rot%0d", k), order[k], (k == 4) ? 0 : k);
      tick();
      bus.done = order[k];
      tick();
      bus.done = '0;
      expect_out($sformatf("s2_gap%0d", k), 4'b0000, 0);
    end
    bus.req = '0;
    repeat (2) tick();

    // Non-owner done ignored; next grant follows the pointer.
    do_reset();
    bus.req = 4'b0100;
    tick();
    expect_out("s3_owner2", 4'b0100, 2);
    bus.req  = 4'b1101;
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    expect_out("s3_hold", 4'b0100, 2);
    bus.done = 4'b0100;
    tick();
    bus.done = '0;
    expect_out("s3_release", 4'b0000, 0);
    tick();
    expect_out("s3_next", 4'b1000, 3);
    bus.req = '0;
    repeat (2) tick();

    // Owner drops req without done.
    do_reset();
    bus.req = 4'b0010;
    tick();
    expect_out("s4_owner1", 4'b0010, 1);
    bus.req = 4'b0101;
    tick();
    expect_out("s4_drop", 4'b0000, 0);
    tick();
    expect_out("s4_ptr2", 4'b0100, 2);
    bus.req = '0;
    repeat (2) tick();

    // Hold limit behaviour.
    do_reset();
    bus.req = 4'b0001;
    if (TO_EN) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        expect_out($sformatf("s5_held%0d", c), 4'b0001, 0);
      end
      tick();
      expect_out("s5_revoke", 4'b0000, 0);
      check("s5_timeout", 32'(bus.timeout), 32'd1);
      tick();
      expect_out("s5_regrant", 4'b0001, 0);
      check("s5_timeout_end", 32'(bus.timeout), 32'd0);
    end else begin
      repeat (105) tick();
      expect_out("s5_still_held", 4'b0001, 0);
      check("s5_no_timeout", 32'(bus.timeout), 32'd0);
    end
    bus.req = '0;
    repeat (2) tick();

    // Asynchronous reset mid-grant, pointer returns to 0.
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1000;
    tick();
    expect_out("s6_owner3", 4'b1000, 3);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("s6_async", 4'b0000, 0);
    bus.req = 4'b1001;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("s6_after", 4'b0001, 0);
    bus.req = '0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with grant locking for a shared 4-way resource.
- Sits in front of the shared resource: takes per-requester request lines and issues one registered one-hot grant.
- Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Pointer-based rotating priority prevents starvation, unlike a plain fixed-priority decode.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum cycles one owner may keep the grant (used only with the timeout feature).
- IDW, $clog2(N), width of grant_id.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request, level; held high while wanting or using the resource.
- done  input  N  per-requester single-cycle release pulse; only the current owner's bit is honoured.
- grant  output  N  one-hot registered grant; all zeros when idle.
- grant_valid  output  1  high while any grant is active; equals |grant.
- grant_id  output  IDW  binary index of the owner; 0 when idle.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async assert, sync deassert):
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- State IDLE:
  - If req!=0, pick the first set bit searching ptr, ptr+1, ..., wrapping modulo N.
  - Register the winner into grant/grant_id, go to BUSY.
  - Latency: grant is visible 1 cycle after req is sampled.
- State BUSY, owner k:
  - Release if done[k]=1 or req[k]=0. Release clears grant next cycle, sets ptr=(k+1) mod N, and returns to IDLE.
  - A grant is always followed by at least one idle cycle (grant=0), so there are no back-to-back grants.
  - done bits of non-owners are ignored.
  - Other req changes have no effect while BUSY.
- Hold counter:
  - Cleared on grant.
  - Increments each BUSY cycle; saturates at MAX_HOLD-1.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle with the updated ptr.
  - done[k] and req[k]=0 together count as one release.
- Wrap-around: ptr=N-1 followed by a release of owner N-1 gives ptr=0.
- req glitch: a requester that deasserts before being granted simply loses its slot; no latched request memory.
- Reset mid-grant: the grant is dropped immediately (asynchronously) and the pointer returns to 0.
- Invariant: grant is always one-hot or zero; grant_id matches grant.

Optional Feature:
- Macro: RR_LOCK_ARBITER_TIMEOUT_EN.
- Defined:
  - If the owner is still BUSY when the hold counter reaches MAX_HOLD-1 (MAX_HOLD cycles of grant), the grant is revoked next cycle.
  - timeout pulses high for exactly that revoke cycle.
  - ptr advances past the owner exactly as on a normal release.
- Not defined:
  - No hold counter is built; the grant is held indefinitely until done or req drop.
  - timeout is tied to 0.

Decomposition:
- Package rr_arb_pkg:
  - State enum {IDLE, BUSY}.
  - Default constants N_DEF=4, MAX_HOLD_DEF=8.
  - Function onehot2bin.
- Sub-module rr_pick: combinational rotate-mask-priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot winner and any_valid.
  - Instantiated once in rr_lock_arbiter; the top holds all state.

Test Plan:
- Reset, then req=0010: grant=0010 and grant_id=1 after 1 cycle. done=0010 gives grant=0000 next cycle and ptr=2.
- req=1111 held, each owner pulses done 2 cycles after grant: grant order 0001, 0010, 0100, 1000, 0001 (wrap), with one idle cycle between each.
- Owner 2 busy, req[0] and req[3] rise, done[0] pulsed (non-owner): grant stays 0100. After done[2], next grant is 1000 (ptr=3).
- Owner 1, req[1] dropped with no done: grant cleared next cycle, ptr=2.
- RR_LOCK_ARBITER_TIMEOUT_EN with MAX_HOLD=8, req=0001 held, no done: grant high for 8 cycles, then timeout=1 for one cycle with grant=0, then regranted to 0001 (only requester). Without the macro, grant stays high for more than 100 cycles and timeout stays 0.
- rst_n asserted low mid-grant (owner 3): grant, grant_valid, and grant_id go to 0 within the same cycle without waiting for clk. After release with req=1001, grant=0001 (ptr reset to 0).
